pong_game_engine: RTL and testbench

- Tick-driven Pong game core: ball physics, paddle motion with clamping, scoring and a serve/play/game-over state machine.
- Every geometric and rule constant is a parameter.
- Sits between the player-input conditioning and the VGA renderer. Outputs top-left coordinates of the ball and both paddles, plus scores for the 7-segment display.
- Replaces the hard-wired, switch-driven ball movement and the unbounded score counting in the current top level.

---
 rtl/pong_pkg.sv | 29 ++
 rtl/pong_game_engine_if.sv | 40 ++++
 rtl/pong_paddle_ctrl.sv | 59 +++++
 rtl/pong_game_engine.sv | 259 +++++++++++++++++++++++++
 tb/tb_pong_game_engine.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared types and default geometry for the Pong game core.
// Defaults here seed the parameters of the engine and paddle blocks.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE     = 2'd1,
    PLAY      = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam int D_SCREEN_W     = 640;
  localparam int D_SCREEN_H     = 480;
  localparam int D_COORD_W      = 11;
  localparam int D_BALL_SIZE    = 25;
  localparam int D_PADDLE_W     = 10;
  localparam int D_PADDLE_H     = 150;
  localparam int D_PADDLE_L_X   = 40;
  localparam int D_PADDLE_R_X   = 600;
  localparam int D_BALL_SPEED   = 4;
  localparam int D_PADDLE_SPEED = 6;
  localparam int D_WIN_SCORE    = 9;
  localparam int D_SERVE_TICKS  = 60;

endpackage

// File: rtl/pong_game_engine_if.sv
// Player-input and game-output bundle of the Pong engine.
// master drives controls and reads positions; slave is the engine.
interface pong_game_engine_if #(
  parameter int COORD_W = 11
);
  logic               tick;
  logic               start;
  logic               p1_up;
  logic               p1_dn;
  logic               p2_up;
  logic               p2_dn;
  logic [COORD_W-1:0] ball_x;
  logic [COORD_W-1:0] ball_y;
  logic [COORD_W-1:0] paddle_l_y;
  logic [COORD_W-1:0] paddle_r_y;
  logic [3:0]         score_l;
  logic [3:0]         score_r;
  logic [1:0]         game_state;
  logic               point_l;
  logic               point_r;
  logic [1:0]         winner;

  modport master (
    output tick, start,
    output p1_up, p1_dn, p2_up, p2_dn,
    input  ball_x, ball_y,
    input  paddle_l_y, paddle_r_y,
    input  score_l, score_r, game_state,
    input  point_l, point_r, winner
  );

  modport slave (
    input  tick, start,
    input  p1_up, p1_dn, p2_up, p2_dn,
    output ball_x, ball_y,
    output paddle_l_y, paddle_r_y,
    output score_l, score_r, game_state,
    output point_l, point_r, winner
  );
endinterface

// File: rtl/pong_paddle_ctrl.sv
// One paddle: tick-driven up/down motion clamped to the screen,
// with a re-centre strobe used when a new game starts.
module pong_paddle_ctrl #(
  parameter int PADDLE_H     = 150,
  parameter int PADDLE_SPEED = 6,
  parameter int SCREEN_H     = 480,
  parameter int COORD_W      = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_tick,
  input  logic               i_enable,
  input  logic               i_center,
  input  logic               i_up,
  input  logic               i_dn,
  output logic [COORD_W-1:0] o_y
);
  typedef logic signed [COORD_W:0] sc_t;

  localparam sc_t C_ZERO = '0;
  localparam sc_t C_SPD  = sc_t'(PADDLE_SPEED);
  localparam sc_t C_MAX  = sc_t'(SCREEN_H - PADDLE_H);
  localparam logic [COORD_W-1:0] C_MID =
    COORD_W'((SCREEN_H - PADDLE_H) / 2);

  logic [COORD_W-1:0] r_y;
  sc_t                w_y;
  sc_t                w_ny;
  sc_t                w_cl;

  assign w_y = {1'b0, r_y};

  // Signed step so a move above the top goes negative and clamps.
  always_comb begin
    w_ny = w_y;
    unique case (1'b1)
      (i_up && !i_dn): w_ny = w_y - C_SPD;
      (i_dn && !i_up): w_ny = w_y + C_SPD;
      default: ;
    endcase
    w_cl = w_ny;
    if (w_ny < C_ZERO)
      w_cl = C_ZERO;
    else if (w_ny > C_MAX)
      w_cl = C_MAX;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_y <= C_MID;
    else if (i_center)
      r_y <= C_MID;
    else if (i_enable && i_tick)
      r_y <= w_cl[COORD_W-1:0];
  end

  assign o_y = r_y;

endmodule

// File: rtl/pong_game_engine.sv
// Pong core: ball physics, paddle hits, scoring and the
// idle/serve/play/game-over sequencing, all stepped by tick.
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = D_SCREEN_W,
  parameter int SCREEN_H     = D_SCREEN_H,
  parameter int COORD_W      = D_COORD_W,
  parameter int BALL_SIZE    = D_BALL_SIZE,
  parameter int PADDLE_W     = D_PADDLE_W,
  parameter int PADDLE_H     = D_PADDLE_H,
  parameter int PADDLE_L_X   = D_PADDLE_L_X,
  parameter int PADDLE_R_X   = D_PADDLE_R_X,
  parameter int BALL_SPEED   = D_BALL_SPEED,
  parameter int PADDLE_SPEED = D_PADDLE_SPEED,
  parameter int WIN_SCORE    = D_WIN_SCORE,
  parameter int SERVE_TICKS  = D_SERVE_TICKS
) (
  input logic               clk,
  input logic               reset,
  pong_game_engine_if.slave bus
);
  typedef logic signed [COORD_W:0] sc_t;
  typedef logic [COORD_W-1:0]      co_t;

  localparam sc_t C_ZERO  = '0;
  localparam sc_t C_S     = sc_t'(BALL_SPEED);
  localparam sc_t C_NS    = sc_t'(-BALL_SPEED);
  localparam sc_t C_BS    = sc_t'(BALL_SIZE);
  localparam sc_t C_PH    = sc_t'(PADDLE_H);
  localparam sc_t C_XMAX  = sc_t'(SCREEN_W - BALL_SIZE);
  localparam sc_t C_YMAX  = sc_t'(SCREEN_H - BALL_SIZE);
  localparam sc_t C_LFACE = sc_t'(PADDLE_L_X + PADDLE_W);
  localparam sc_t C_RFACE = sc_t'(PADDLE_R_X);
  localparam sc_t C_RSTOP = sc_t'(PADDLE_R_X - BALL_SIZE);
  localparam co_t C_BX0   = co_t'((SCREEN_W - BALL_SIZE) / 2);
  localparam co_t C_BY0   = co_t'((SCREEN_H - BALL_SIZE) / 2);
  localparam int  CNT_W   = $clog2(SERVE_TICKS + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST =
    CNT_W'(SERVE_TICKS - 1);
  localparam logic [3:0] C_WIN = 4'(WIN_SCORE);

  game_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  co_t              r_bx;
  co_t              r_by;
  sc_t              r_vx;
  sc_t              r_vy;
  logic [3:0]       r_sl;
  logic [3:0]       r_sr;
  logic [1:0]       r_win;
  logic             r_pt_l;
  logic             r_pt_r;

  co_t        w_pl_y;
  co_t        w_pr_y;
  logic       w_pad_en;
  logic       w_center;
  sc_t        w_bx;
  sc_t        w_by;
  sc_t        w_nx;
  sc_t        w_ny;
  sc_t        w_ply;
  sc_t        w_pry;
  sc_t        w_bx_n;
  sc_t        w_vx_n;
  sc_t        w_by_n;
  sc_t        w_vy_n;
  logic       w_ov_l;
  logic       w_ov_r;
  logic       w_hit_l;
  logic       w_hit_r;
  logic       w_goal_l;
  logic       w_goal_r;
  logic [3:0] w_sl_n;
  logic [3:0] w_sr_n;

  assign w_pad_en = (r_state == SERVE) || (r_state == PLAY);
  assign w_center = (r_state == GAME_OVER) && bus.start;

  pong_paddle_ctrl #(
    .PADDLE_H     (PADDLE_H),
    .PADDLE_SPEED (PADDLE_SPEED),
    .SCREEN_H     (SCREEN_H),
    .COORD_W      (COORD_W)
  ) u_pad_l (
    .clk      (clk),
    .reset    (reset),
    .i_tick   (bus.tick),
    .i_enable (w_pad_en),
    .i_center (w_center),
    .i_up     (bus.p1_up),
    .i_dn     (bus.p1_dn),
    .o_y      (w_pl_y)
  );

  pong_paddle_ctrl #(
    .PADDLE_H     (PADDLE_H),
    .PADDLE_SPEED (PADDLE_SPEED),
    .SCREEN_H     (SCREEN_H),
    .COORD_W      (COORD_W)
  ) u_pad_r (
    .clk      (clk),
    .reset    (reset),
    .i_tick   (bus.tick),
    .i_enable (w_pad_en),
    .i_center (w_center),
    .i_up     (bus.p2_up),
    .i_dn     (bus.p2_dn),
    .o_y      (w_pr_y)
  );

  assign w_bx  = {1'b0, r_bx};
  assign w_by  = {1'b0, r_by};
  assign w_ply = {1'b0, w_pl_y};
  assign w_pry = {1'b0, w_pr_y};
  assign w_nx  = w_bx + r_vx;
  assign w_ny  = w_by + r_vy;

  // Overlap uses pre-tick ball and paddle positions.
  assign w_ov_l = (w_by + C_BS > w_ply) && (w_by < w_ply + C_PH);
  assign w_ov_r = (w_by + C_BS > w_pry) && (w_by < w_pry + C_PH);

  assign w_hit_l = (r_vx < C_ZERO) && (w_bx >= C_LFACE)
                && (w_nx <= C_LFACE) && w_ov_l;
  assign w_hit_r = (r_vx > C_ZERO) && (w_bx + C_BS <= C_RFACE)
                && (w_nx + C_BS >= C_RFACE) && w_ov_r;

  assign w_goal_l = !w_hit_l && !w_hit_r && (w_nx >= C_XMAX);
  assign w_goal_r = !w_hit_l && !w_hit_r && (w_nx <= C_ZERO);

  assign w_sl_n = r_sl + 4'd1;
  assign w_sr_n = r_sr + 4'd1;

  always_comb begin
    w_by_n = w_ny;
    w_vy_n = r_vy;
    if (w_ny <= C_ZERO) begin
      w_by_n = C_ZERO;
      w_vy_n = C_S;
    end else if (w_ny >= C_YMAX) begin
      w_by_n = C_YMAX;
      w_vy_n = C_NS;
    end
  end

  always_comb begin
    w_bx_n = w_nx;
    w_vx_n = r_vx;
    unique case (1'b1)
      w_hit_l: begin
        w_bx_n = C_LFACE;
        w_vx_n = C_S;
      end
      w_hit_r: begin
        w_bx_n = C_RSTOP;
        w_vx_n = C_NS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bx    <= C_BX0;
      r_by    <= C_BY0;
      r_vx    <= C_S;
      r_vy    <= C_S;
      r_sl    <= '0;
      r_sr    <= '0;
      r_win   <= WIN_NONE;
      r_pt_l  <= 1'b0;
      r_pt_r  <= 1'b0;
    end else begin
      r_pt_l <= 1'b0;
      r_pt_r <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= SERVE;
            r_cnt   <= '0;
            r_sl    <= '0;
            r_sr    <= '0;
            r_win   <= WIN_NONE;
          end
        end
        SERVE: begin
          if (bus.tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == C_CNT_LAST)
              r_state <= PLAY;
          end
        end
        PLAY: begin
          if (bus.tick) begin
            r_bx <= w_bx_n[COORD_W-1:0];
            r_by <= w_by_n[COORD_W-1:0];
            r_vx <= w_vx_n;
            r_vy <= w_vy_n;
            // Scorer's serve goes toward the player who conceded.
            if (w_goal_l) begin
              r_sl   <= w_sl_n;
              r_pt_l <= 1'b1;
              r_bx   <= C_BX0;
              r_by   <= C_BY0;
              r_vx   <= C_S;
              if (w_sl_n == C_WIN) begin
                r_state <= GAME_OVER;
                r_win   <= WIN_LEFT;
              end else begin
                r_state <= SERVE;
                r_cnt   <= '0;
              end
            end else if (w_goal_r) begin
              r_sr   <= w_sr_n;
              r_pt_r <= 1'b1;
              r_bx   <= C_BX0;
              r_by   <= C_BY0;
              r_vx   <= C_NS;
              if (w_sr_n == C_WIN) begin
                r_state <= GAME_OVER;
                r_win   <= WIN_RIGHT;
              end else begin
                r_state <= SERVE;
                r_cnt   <= '0;
              end
            end
          end
        end
        GAME_OVER: begin
          if (bus.start) begin
            r_state <= SERVE;
            r_cnt   <= '0;
            r_sl    <= '0;
            r_sr    <= '0;
            r_win   <= WIN_NONE;
            r_bx    <= C_BX0;
            r_by    <= C_BY0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ball_x     = r_bx;
  assign bus.ball_y     = r_by;
  assign bus.paddle_l_y = w_pl_y;
  assign bus.paddle_r_y = w_pr_y;
  assign bus.score_l    = r_sl;
  assign bus.score_r    = r_sr;
  assign bus.game_state = r_state;
  assign bus.point_l    = r_pt_l;
  assign bus.point_r    = r_pt_r;
  assign bus.winner     = r_win;

endmodule

// File: tb/tb_pong_game_engine.sv
// Bench for pong_game_engine: rule-level game model feeds a queue
// of expected outputs that a monitor compares every clock.
module tb_pong_game_engine;

  localparam int S    = 4;
  localparam int BS   = 25;
  localparam int PH   = 150;
  localparam int SH   = 480;
  localparam int SWD  = 640;
  localparam int PSPD = 6;
  localparam int LFACE = 50;
  localparam int RFACE = 600;

  typedef struct packed {
    logic [10:0] bx;
    logic [10:0] by;
    logic [10:0] pl;
    logic [10:0] pr;
    logic [3:0]  sl;
    logic [3:0]  sr;
    logic [1:0]  st;
    logic        ptl;
    logic        ptr;
    logic [1:0]  win;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_game_engine_if bus ();

  pong_game_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  obs_t q[$];

  int m_bx, m_by, m_vx, m_vy, m_pl, m_pr;
  int m_sl, m_sr, m_st, m_cnt, m_win, m_ptl, m_ptr;

  function automatic string fmt(obs_t o);
    return $sformatf(
      "ball=(%0d,%0d) pad=(%0d,%0d) sc=%0d:%0d st=%0d pt=%0d%0d win=%0d",
      o.bx, o.by, o.pl, o.pr, o.sl, o.sr, o.st, o.ptl, o.ptr, o.win);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.bx  = bus.ball_x;
    o.by  = bus.ball_y;
    o.pl  = bus.paddle_l_y;
    o.pr  = bus.paddle_r_y;
    o.sl  = bus.score_l;
    o.sr  = bus.score_r;
    o.st  = bus.game_state;
    o.ptl = bus.point_l;
    o.ptr = bus.point_r;
    o.win = bus.winner;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.bx  = 11'(m_bx);
    o.by  = 11'(m_by);
    o.pl  = 11'(m_pl);
    o.pr  = 11'(m_pr);
    o.sl  = 4'(m_sl);
    o.sr  = 4'(m_sr);
    o.st  = 2'(m_st);
    o.ptl = 1'(m_ptl);
    o.ptr = 1'(m_ptr);
    o.win = 2'(m_win);
    return o;
  endfunction

  function automatic int pad_move(int y, bit up, bit dn);
    int n;
    n = y;
    if (up && !dn) n = y - PSPD;
    if (dn && !up) n = y + PSPD;
    if (n < 0) n = 0;
    if (n > SH - PH) n = SH - PH;
    return n;
  endfunction

  task automatic score(input bit left);
    m_bx = (SWD - BS) / 2;
    m_by = (SH - BS) / 2;
    if (left) begin
      m_sl++; m_ptl = 1; m_vx = S;
    end else begin
      m_sr++; m_ptr = 1; m_vx = -S;
    end
    if (m_sl == 9 || m_sr == 9) begin
      m_st = 3;
      m_win = left ? 1 : 2;
    end else begin
      m_st = 1;
      m_cnt = 0;
    end
  endtask

  task automatic play_tick();
    int nx, ny;
    bit ovl, ovr;
    nx = m_bx + m_vx;
    ny = m_by + m_vy;
    ovl = (m_by + BS > m_pl) && (m_by < m_pl + PH);
    ovr = (m_by + BS > m_pr) && (m_by < m_pr + PH);
    if (ny <= 0) begin
      m_by = 0; m_vy = S;
    end else if (ny >= SH - BS) begin
      m_by = SH - BS; m_vy = -S;
    end else m_by = ny;
    if (m_vx < 0 && m_bx >= LFACE && nx <= LFACE && ovl) begin
      m_bx = LFACE; m_vx = S;
    end else if (m_vx > 0 && m_bx + BS <= RFACE
                 && nx + BS >= RFACE && ovr) begin
      m_bx = RFACE - BS; m_vx = -S;
    end else if (nx >= SWD - BS) score(1'b1);
    else if (nx <= 0) score(1'b0);
    else m_bx = nx;
  endtask

  task automatic model_step(input bit rst, tk, st,
                            input bit u1, d1, u2, d2);
    m_ptl = 0;
    m_ptr = 0;
    if (rst) begin
      m_bx = 307; m_by = 227; m_vx = S; m_vy = S;
      m_pl = 165; m_pr = 165; m_sl = 0; m_sr = 0;
      m_st = 0; m_cnt = 0; m_win = 0;
    end else if (m_st == 0) begin
      if (st) begin
        m_st = 1; m_cnt = 0; m_sl = 0; m_sr = 0; m_win = 0;
      end
    end else if (m_st == 1) begin
      if (tk) begin
        m_cnt++;
        if (m_cnt == 60) m_st = 2;
        m_pl = pad_move(m_pl, u1, d1);
        m_pr = pad_move(m_pr, u2, d2);
      end
    end else if (m_st == 2) begin
      if (tk) begin
        play_tick();
        m_pl = pad_move(m_pl, u1, d1);
        m_pr = pad_move(m_pr, u2, d2);
      end
    end else if (st) begin
      m_sl = 0; m_sr = 0; m_win = 0;
      m_bx = 307; m_by = 227; m_pl = 165; m_pr = 165;
      m_st = 1; m_cnt = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = sample();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle@%0t got %s want %s",
                   $time, fmt(a), fmt(e));
        end
      end
    end
  end

  task automatic step(input bit rst, tk, st,
                      input bit u1, d1, u2, d2);
    @(negedge clk);
    reset     = rst;
    bus.tick  = tk;
    bus.start = st;
    bus.p1_up = u1;
    bus.p1_dn = d1;
    bus.p2_up = u2;
    bus.p2_dn = d2;
    model_step(rst, tk, st, u1, d1, u2, d2);
    q.push_back(model_obs());
    @(posedge clk);
    #2;
  endtask

  task automatic tk(input bit u1, d1, u2, d2);
    step(0, 1, 0, u1, d1, u2, d2);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_bx"}, 32'(bus.ball_x), 307);
    chk({nm, "_by"}, 32'(bus.ball_y), 227);
    chk({nm, "_pl"}, 32'(bus.paddle_l_y), 165);
    chk({nm, "_pr"}, 32'(bus.paddle_r_y), 165);
    chk({nm, "_st"}, 32'(bus.game_state), 0);
    chk({nm, "_sl"}, 32'(bus.score_l), 0);
    chk({nm, "_sr"}, 32'(bus.score_r), 0);
    chk({nm, "_win"}, 32'(bus.winner), 0);
  endtask

  initial begin
    int n;
    bit u1, d1, u2, d2;
    logic [31:0] r;
    reset = 1'b1;
    bus.tick = 0; bus.start = 0;
    bus.p1_up = 0; bus.p1_dn = 0;
    bus.p2_up = 0; bus.p2_dn = 0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (5) tk(0, 0, 0, 0);
    check_reset_vals("idle");

    step(0, 0, 1, 0, 0, 0, 0);
    chk("serve_st", 32'(bus.game_state), 1);
    repeat (60) tk(0, 0, 0, 0);
    chk("play_st", 32'(bus.game_state), 2);
    tk(0, 0, 0, 0);
    chk("first_bx", 32'(bus.ball_x), 311);
    chk("first_by", 32'(bus.ball_y), 231);
    n = 1;
    while (bus.score_l == 0 && n < 200) begin
      tk(0, 0, 0, 0);
      n++;
    end
    chk("miss_tick", 32'(n), 77);
    chk("miss_sl", 32'(bus.score_l), 1);
    chk("miss_bx", 32'(bus.ball_x), 307);
    chk("miss_by", 32'(bus.ball_y), 227);
    chk("miss_st", 32'(bus.game_state), 1);

    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    repeat (60) tk(0, 0, 0, 1);
    chk("clamp_pr", 32'(bus.paddle_r_y), 330);
    repeat (67) tk(0, 0, 0, 1);
    chk("hit_bx", 32'(bus.ball_x), 575);
    chk("hit_by", 32'(bus.ball_y), 415);
    chk("hit_sl", 32'(bus.score_l), 0);
    repeat (10) tk(1, 1, 0, 1);
    chk("both_pl", 32'(bus.paddle_l_y), 165);

    // Left paddle tracks the ball, right paddle dodges it.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    n = 0;
    while (bus.game_state != 2'd3 && n < 4000) begin
      u1 = (m_pl + 75 > m_by + 12 + 8);
      d1 = (m_pl + 75 < m_by + 12 - 8);
      d2 = (m_by + 12 < 240);
      u2 = !d2;
      tk(u1, d1, u2, d2);
      n++;
    end
    chk("go_st", 32'(bus.game_state), 3);
    chk("go_win", 32'(bus.winner), 1);
    chk("go_sl", 32'(bus.score_l), 9);
    repeat (5) begin
      r = $urandom;
      tk(r[0], r[1], r[2], r[3]);
    end
    chk("frozen_sl", 32'(bus.score_l), 9);
    chk("frozen_st", 32'(bus.game_state), 3);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("restart_sl", 32'(bus.score_l), 0);
    chk("restart_st", 32'(bus.game_state), 1);
    chk("restart_win", 32'(bus.winner), 0);

    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    repeat (70) tk(0, 0, 1, 0);
    chk("mid_st", 32'(bus.game_state), 2);
    step(1, 1, 1, 1, 1, 1, 1);
    check_reset_vals("midrst");

    for (int i = 0; i < 4000; i++) begin
      r = $urandom;
      step(r[27:19] == 0, r[0], r[15:10] == 0,
           r[1], r[2], r[3], r[4]);
    end

    step(0, 0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
